mul4_fitness_sequencer: RTL and testbench

Sequences fitness evaluation of one combinational bit-sliced 2x2 multiplier candidate (ports a1,a0,b1,b0 in; y3..y0 out; 16 lanes of 16 bits each).
- Drives all 16 operand combinations (one per lane) onto the candidate and waits a settle window.
- Samples its outputs, compares them lane-by-lane against the golden product, and accumulates the number of correct output bits.
- Repeats over NUM_PASSES lane rotations, then returns the score over a valid/ready handshake.
- Sits between the evolutionary fitness harness and the instantiated candidate.

---
 rtl/mul4_seq_pkg.sv | 43 ++++
 rtl/mul4_lane_scorer.sv | 37 +++
 rtl/mul4_fitness_sequencer.sv | 152 +++++++++++++++
 tb/tb_mul4_fitness_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_seq_pkg.sv
// rtl/mul4_seq_pkg.sv - shared types, test patterns and helpers for the 2x2 multiplier fitness sequencer
package mul4_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int LANES         = 16;
  localparam int BITS_PER_PASS = 64;

  // Lane i of the pass-0 stimulus carries case k=i with a=k[3:2], b=k[1:0]
  localparam logic [LANES-1:0] BASE_A1 = 16'hFF00;
  localparam logic [LANES-1:0] BASE_A0 = 16'hF0F0;
  localparam logic [LANES-1:0] BASE_B1 = 16'hCCCC;
  localparam logic [LANES-1:0] BASE_B0 = 16'hAAAA;

  // Golden product bits for the same lane ordering
  localparam logic [LANES-1:0] GOLD_Y3 = 16'h8000;
  localparam logic [LANES-1:0] GOLD_Y2 = 16'h4C00;
  localparam logic [LANES-1:0] GOLD_Y1 = 16'h6AC0;
  localparam logic [LANES-1:0] GOLD_Y0 = 16'hA0A0;

  // Rotate a lane vector right; shifting a doubled copy avoids a zero-width corner at sh=0
  function automatic logic [LANES-1:0] ror16(input logic [LANES-1:0] v, input logic [3:0] sh);
    logic [2*LANES-1:0] w;
    w = {v, v} >> sh;
    return w[LANES-1:0];
  endfunction

  // Count set bits in one lane vector
  function automatic logic [4:0] popcount16(input logic [LANES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mul4_lane_scorer.sv
// rtl/mul4_lane_scorer.sv - rotated golden vectors and per-pass match count for one candidate sample
module mul4_lane_scorer
  import mul4_seq_pkg::*;
(
  input  logic [3:0]       i_pass,
  input  logic [LANES-1:0] i_y3,
  input  logic [LANES-1:0] i_y2,
  input  logic [LANES-1:0] i_y1,
  input  logic [LANES-1:0] i_y0,
  output logic [LANES-1:0] o_g3,
  output logic [LANES-1:0] o_g2,
  output logic [LANES-1:0] o_g1,
  output logic [LANES-1:0] o_g0,
  output logic [6:0]       o_match
);

  logic [4:0] w_pc3;
  logic [4:0] w_pc2;
  logic [4:0] w_pc1;
  logic [4:0] w_pc0;

  // Golden vectors follow the stimulus rotation so lane i always compares against case (i+pass) mod 16
  assign o_g3 = ror16(GOLD_Y3, i_pass);
  assign o_g2 = ror16(GOLD_Y2, i_pass);
  assign o_g1 = ror16(GOLD_Y1, i_pass);
  assign o_g0 = ror16(GOLD_Y0, i_pass);

  // Count agreeing bits per output plane, then sum the four planes (0..64 fits in 7 bits)
  always_comb begin
    w_pc3   = popcount16(~(i_y3 ^ o_g3));
    w_pc2   = popcount16(~(i_y2 ^ o_g2));
    w_pc1   = popcount16(~(i_y1 ^ o_g1));
    w_pc0   = popcount16(~(i_y0 ^ o_g0));
    o_match = 7'(w_pc3) + 7'(w_pc2) + 7'(w_pc1) + 7'(w_pc0);
  end

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// rtl/mul4_fitness_sequencer.sv - drives, samples and scores a bit-sliced 2x2 multiplier candidate
module mul4_fitness_sequencer
  import mul4_seq_pkg::*;
#(
  parameter int  NUM_PASSES    = 4,
  parameter int  SETTLE_CYCLES = 2,
  localparam int SCORE_W       = $clog2(64 * NUM_PASSES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic [LANES-1:0]   stim_a1,
  output logic [LANES-1:0]   stim_a0,
  output logic [LANES-1:0]   stim_b1,
  output logic [LANES-1:0]   stim_b0,
  input  logic [LANES-1:0]   dut_y3,
  input  logic [LANES-1:0]   dut_y2,
  input  logic [LANES-1:0]   dut_y1,
  input  logic [LANES-1:0]   dut_y0,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
);

  localparam int               SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       PASS_LAST = 4'(NUM_PASSES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(BITS_PER_PASS * NUM_PASSES);

  state_t             r_state;
  logic [3:0]         r_pass;
  logic [SET_W-1:0]   r_settle;
  logic [SCORE_W-1:0] r_acc;
  logic               r_valid;
  logic [LANES-1:0]   r_stim_a1;
  logic [LANES-1:0]   r_stim_a0;
  logic [LANES-1:0]   r_stim_b1;
  logic [LANES-1:0]   r_stim_b0;

  logic [LANES-1:0]   w_g3;
  logic [LANES-1:0]   w_g2;
  logic [LANES-1:0]   w_g1;
  logic [LANES-1:0]   w_g0;
  logic [6:0]         w_match;
  logic [3:0]         w_pass_next;

  mul4_lane_scorer u_scorer (
    .i_pass  (r_pass),
    .i_y3    (dut_y3),
    .i_y2    (dut_y2),
    .i_y1    (dut_y1),
    .i_y0    (dut_y0),
    .o_g3    (w_g3),
    .o_g2    (w_g2),
    .o_g1    (w_g1),
    .o_g0    (w_g0),
    .o_match (w_match)
  );

  assign w_pass_next = r_pass + 4'd1;

  // Sequencer FSM: load stimulus, settle, sample and accumulate, then hold the result for the harness
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pass    <= '0;
      r_settle  <= '0;
      r_acc     <= '0;
      r_valid   <= 1'b0;
      r_stim_a1 <= '0;
      r_stim_a0 <= '0;
      r_stim_b1 <= '0;
      r_stim_b0 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // abort is meaningless here, so start alone decides
          if (start) begin
            r_state   <= ST_DRIVE;
            r_pass    <= '0;
            r_settle  <= '0;
            r_acc     <= '0;
            r_stim_a1 <= BASE_A1;
            r_stim_a0 <= BASE_A0;
            r_stim_b1 <= BASE_B1;
            r_stim_b0 <= BASE_B0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_settle <= '0;
          end else if (r_settle == SET_LAST) begin
            r_settle <= '0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_valid <= 1'b0;
          end else begin
            r_acc <= r_acc + SCORE_W'(w_match);
            if (r_pass == PASS_LAST) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
            end else begin
              r_pass    <= w_pass_next;
              r_stim_a1 <= ror16(BASE_A1, w_pass_next);
              r_stim_a0 <= ror16(BASE_A0, w_pass_next);
              r_stim_b1 <= ror16(BASE_B1, w_pass_next);
              r_stim_b0 <= ror16(BASE_B0, w_pass_next);
              r_state   <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even in the handshake cycle
          if (abort) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_valid <= 1'b0;
          end else if (res_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign res_valid = r_valid;
  assign score     = r_acc;
  assign perfect   = r_valid && (r_acc == SCORE_MAX);
  assign stim_a1   = r_stim_a1;
  assign stim_a0   = r_stim_a0;
  assign stim_b1   = r_stim_b1;
  assign stim_b0   = r_stim_b0;

endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// tb/tb_mul4_fitness_sequencer.sv - directed self-checking bench for the multiplier fitness sequencer
module tb_mul4_fitness_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic [15:0] stim_a1, stim_a0, stim_b1, stim_b0;
  logic [15:0] dut_y3, dut_y2, dut_y1, dut_y0;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  score;
  logic        perfect;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  typedef struct {
    string name;
    int    mode;
    int    exp_score;
    logic  exp_perfect;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  mul4_fitness_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .stim_a1   (stim_a1),
    .stim_a0   (stim_a0),
    .stim_b1   (stim_b1),
    .stim_b0   (stim_b0),
    .dut_y3    (dut_y3),
    .dut_y2    (dut_y2),
    .dut_y1    (dut_y1),
    .dut_y0    (dut_y0),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .score     (score),
    .perfect   (perfect)
  );

  // Candidate model: a behavioural 2x2 multiplier per lane, optionally corrupted by mode
  always_comb begin
    logic [3:0] p;
    p      = '0;
    dut_y3 = '0;
    dut_y2 = '0;
    dut_y1 = '0;
    dut_y0 = '0;
    for (int i = 0; i < 16; i++) begin
      p = {2'b00, stim_a1[i], stim_a0[i]} * {2'b00, stim_b1[i], stim_b0[i]};
      dut_y3[i] = p[3];
      dut_y2[i] = p[2];
      dut_y1[i] = p[1];
      dut_y0[i] = p[0];
    end
    case (mode)
      1: begin dut_y3 = '0; dut_y2 = '0; dut_y1 = '0; dut_y0 = '0; end
      2: begin dut_y3 = '1; dut_y2 = '1; dut_y1 = '1; dut_y0 = '1; end
      3: dut_y0 = ~dut_y0;
      4: dut_y3[0] = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one evaluation and wait (bounded) for res_valid; checks pass-0/pass-1 stimulus and latency
  task automatic run_to_done(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    check({tag, " pass0 a1"}, 32'(stim_a1), 32'hFF00);
    check({tag, " pass0 a0"}, 32'(stim_a0), 32'hF0F0);
    check({tag, " pass0 b1"}, 32'(stim_b1), 32'hCCCC);
    check({tag, " pass0 b0"}, 32'(stim_b0), 32'hAAAA);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
      if (n == 3) begin
        check({tag, " pass1 a1"}, 32'(stim_a1), 32'h7F80);
        check({tag, " pass1 b0"}, 32'(stim_b0), 32'h5555);
      end
    end
    check({tag, " latency"}, 32'(n), 32'd12);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " valid drops"}, 32'(res_valid), 32'd0);
    check({tag, " idle after ready"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   n;
    logic seen_valid;

    vecs[0] = '{name: "correct",  mode: 0, exp_score: 256, exp_perfect: 1'b1};
    vecs[1] = '{name: "zeros",    mode: 1, exp_score: 200, exp_perfect: 1'b0};
    vecs[2] = '{name: "ones",     mode: 2, exp_score: 56,  exp_perfect: 1'b0};
    vecs[3] = '{name: "y0_inv",   mode: 3, exp_score: 192, exp_perfect: 1'b0};
    vecs[4] = '{name: "lane0_y3", mode: 4, exp_score: 252, exp_perfect: 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(res_valid), 32'd0);
    check("reset score", 32'(score), 32'd0);
    check("reset perfect", 32'(perfect), 32'd0);
    check("reset stim", {stim_a1, stim_b0}, 32'd0);
    rst = 1'b0;
    tick();

    // Table of candidates with hand-computed totals
    for (int v = 0; v < 5; v++) begin
      mode = vecs[v].mode;
      run_to_done(vecs[v].name);
      check({vecs[v].name, " score"}, 32'(score), 32'(vecs[v].exp_score));
      check({vecs[v].name, " perfect"}, 32'(perfect), 32'(vecs[v].exp_perfect));
      handshake(vecs[v].name);
      tick();
    end

    // DONE holds with res_ready low; start pulses ignored, including in the handshake cycle
    mode = 0;
    run_to_done("hold");
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      tick();
      check("hold valid", 32'(res_valid), 32'd1);
      check("hold score", 32'(score), 32'd256);
      check("hold busy", 32'(busy), 32'd1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("handshake idle", 32'(busy), 32'd0);
    check("handshake valid", 32'(res_valid), 32'd0);
    tick();
    check("start in handshake ignored", 32'(busy), 32'd0);

    // abort in the second SAMPLE cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(res_valid), 32'd0);
    seen_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (res_valid) seen_valid = 1'b1;
    end
    check("abort no result", 32'(seen_valid), 32'd0);
    run_to_done("after_abort");
    check("after abort score", 32'(score), 32'd256);
    check("after abort perfect", 32'(perfect), 32'd1);
    handshake("after_abort");

    // rst mid-DRIVE returns every output to reset values
    start = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst valid", 32'(res_valid), 32'd0);
    check("midrst score", 32'(score), 32'd0);
    check("midrst perfect", 32'(perfect), 32'd0);
    check("midrst stim ab", {stim_a1, stim_a0}, 32'd0);
    check("midrst stim b", {stim_b1, stim_b0}, 32'd0);

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 32'(busy), 32'd1);
    check("start+abort stim", 32'(stim_a1), 32'hFF00);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check("start+abort latency", 32'(n), 32'd12);
    check("start+abort score", 32'(score), 32'd256);
    handshake("start+abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
